// File: rtl/lagrange_out_stage.sv
// Output stage behind the 6-tap Lagrange FIR: aligns validity, drops warm-up samples,
// rounds/saturates to OUT_W bits and buffers results in a small valid/ready FIFO.
module lagrange_out_stage #(
  parameter int IN_W       = 46,
  parameter int OUT_W      = 16,
  parameter int FRAC       = 10,
  parameter int FIR_LAT    = 2,
  parameter int N_TAPS     = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   fir_long,
  input  logic              clr,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [3:0]        fill,
  output logic              sat_flag,
  output logic [15:0]       sat_count,
  output logic              ovf_flag
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(N_TAPS);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(N_TAPS - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic signed [IN_W:0] HALF    = (IN_W+1)'(1) <<< (FRAC - 1);
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

  logic [FIR_LAT-1:0]      r_vpipe;
  logic [CNT_W-1:0]        r_run;
  logic signed [IN_W:0]    r_round;
  logic                    r_rv;
  logic [OUT_W-1:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_count;
  logic [OUT_W-1:0]        r_last;
  logic                    r_sat_flag;
  logic [15:0]             r_sat_count;
  logic                    r_ovf_flag;

  logic                    w_v_al;
  logic                    w_keep;
  logic signed [IN_W:0]    w_sum;
  logic                    w_hi;
  logic                    w_lo;
  logic                    w_clamp;
  logic [OUT_W-1:0]        w_sat_data;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_wr;
  logic                    w_drop;

  assign w_v_al = r_vpipe[FIR_LAT-1];
  // A run only yields settled FIR output once its history holds N_TAPS real samples.
  assign w_keep = w_v_al && (r_run == RUN_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vpipe <= '0;
      r_run   <= '0;
      r_round <= '0;
      r_rv    <= 1'b0;
    end else begin
      r_vpipe[0] <= in_valid;
      for (int i = 1; i < FIR_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
      if (!w_v_al)              r_run <= '0;
      else if (r_run != RUN_MAX) r_run <= r_run + CNT_W'(1);
      r_round <= w_sum >>> FRAC;
      r_rv    <= w_keep;
    end
  end

  // One extra sign bit so adding the half-LSB can never wrap.
  assign w_sum = $signed({fir_long[IN_W-1], fir_long}) + HALF;

  assign w_hi    = r_round > SAT_MAX;
  assign w_lo    = r_round < SAT_MIN;
  assign w_clamp = r_rv && (w_hi || w_lo);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_sat_data = r_round[OUT_W-1:0];
    if (w_hi)      w_sat_data = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_lo) w_sat_data = {1'b1, {(OUT_W-1){1'b0}}};
  end

  assign m_valid = (r_count != '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = m_valid && m_ready;
  assign w_wr    = r_rv && (!w_full || w_pop);
  assign w_drop  = r_rv && w_full && !w_pop;

  // NOTE: storage array has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_sat_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new event in the same cycle as clr must survive, so events take priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat_flag  <= 1'b0;
      r_sat_count <= '0;
      r_ovf_flag  <= 1'b0;
    end else begin
      if (w_clamp) begin
        r_sat_flag <= 1'b1;
        if (clr)                     r_sat_count <= 16'd1;
        else if (r_sat_count != '1)  r_sat_count <= r_sat_count + 16'd1;
      end else if (clr) begin
        r_sat_flag  <= 1'b0;
        r_sat_count <= '0;
      end
      if (w_drop)   r_ovf_flag <= 1'b1;
      else if (clr) r_ovf_flag <= 1'b0;
    end
  end

  // When empty, the last consumed sample stays on the bus.
  assign m_data    = m_valid ? r_mem[r_rd_ptr] : r_last;
  assign fill      = 4'(r_count);
  assign sat_flag  = r_sat_flag;
  assign sat_count = r_sat_count;
  assign ovf_flag  = r_ovf_flag;

endmodule

// File: tb/tb_lagrange_out_stage.sv
// Bench for lagrange_out_stage: a queue-based reference model checked every cycle,
// plus directed runs with hand-computed expected samples.
module tb_lagrange_out_stage;

  localparam int FIR_LAT = 2;
  localparam int N_TAPS  = 6;
  localparam int FRAC    = 10;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [45:0] fir_long = '0;
  logic        clr = 1'b0;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic        m_valid;
  logic [3:0]  fill;
  logic        sat_flag;
  logic [15:0] sat_count;
  logic        ovf_flag;

  lagrange_out_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .fir_long(fir_long), .clr(clr),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fill(fill),
    .sat_flag(sat_flag), .sat_count(sat_count), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     mq[$];
  int     m_last = 0;
  bit     pend_v = 0;
  longint pend_val = 0;
  int     run_pos = 0;
  bit     vh[FIR_LAT];
  bit     e_sat = 0;
  int     e_cnt = 0;
  bit     e_ovf = 0;
  bit     mdl_pop, mdl_full, ev_sat, ev_drop, mdl_val;
  int     mdl_s;

  function automatic int sat16(input longint r);
    if (r > 32767)  return 32767;
    if (r < -32768) return -32768;
    return int'(r);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_last = 0; pend_v = 0; pend_val = 0; run_pos = 0;
      for (int i = 0; i < FIR_LAT; i++) vh[i] = 1'b0;
      e_sat = 0; e_cnt = 0; e_ovf = 0;
    end else begin
      mdl_full = (mq.size() == DEPTH);
      mdl_pop  = (mq.size() > 0) && m_ready;
      ev_sat = 0; ev_drop = 0;
      if (mdl_pop) m_last = mq.pop_front();
      if (pend_v) begin
        mdl_s  = sat16(pend_val);
        ev_sat = (longint'(mdl_s) != pend_val);
        if (!mdl_full || mdl_pop) mq.push_back(mdl_s);
        else                      ev_drop = 1;
      end
      if (ev_sat) begin
        e_sat = 1;
        e_cnt = clr ? 1 : ((e_cnt == 65535) ? 65535 : e_cnt + 1);
      end else if (clr) begin
        e_sat = 0; e_cnt = 0;
      end
      if (ev_drop)  e_ovf = 1;
      else if (clr) e_ovf = 0;
      // Sample index within the current uninterrupted run; the first N_TAPS-1 are transient.
      mdl_val  = vh[FIR_LAT-1];
      run_pos  = mdl_val ? run_pos + 1 : 0;
      pend_v   = mdl_val && (run_pos > N_TAPS - 1);
      pend_val = (longint'($signed(fir_long)) + (longint'(1) << (FRAC - 1))) >>> FRAC;
      for (int i = FIR_LAT - 1; i > 0; i--) vh[i] = vh[i-1];
      vh[0] = in_valid;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  int got_q[$];

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_valid", m_valid, mq.size() != 0);
      check("fill", fill, mq.size());
      if (mq.size() != 0) check("m_data_head", $signed(m_data), mq[0]);
      else                check("m_data_hold", $signed(m_data), m_last);
      check("sat_flag", sat_flag, e_sat);
      check("sat_count", sat_count, e_cnt);
      check("ovf_flag", ovf_flag, e_ovf);
      if (m_valid && m_ready) got_q.push_back(int'($signed(m_data)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      fir_long = '0;
    end
  endtask

  // fir_long trails in_valid by FIR_LAT cycles, mimicking the FIR.
  // rdy_idx >= 0 gives a one-cycle m_ready pulse at that cycle index.
  task automatic send_run(input longint vals[$], input int rdy_idx, input int tail);
    int n;
    n = vals.size();
    for (int k = 0; k < n + FIR_LAT + tail; k++) begin
      @(posedge clk); #1;
      in_valid = (k < n);
      fir_long = (k >= FIR_LAT && k - FIR_LAT < n) ? 46'(vals[k-FIR_LAT]) : '0;
      if (rdy_idx >= 0) begin
        if (k == rdy_idx)          m_ready = 1'b1;
        else if (k == rdy_idx + 1) m_ready = 1'b0;
      end
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  longint v[$];
  int     base;
  int     exp2[4] = '{-1, -2, 1, 0};
  longint t2[4]   = '{-1536, -2560, 1023, 511};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_fill", fill, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_ovf_flag", ovf_flag, 0);
    reset = 1'b1;
    cmp_en = 1;
    idle(2);

    // 1: ten contiguous samples of 1.5 -> five outputs of 2
    base = got_q.size();
    v.delete(); repeat (10) v.push_back(1536);
    send_run(v, -1, 0);
    idle(6);
    check("t1_count", got_q.size() - base, 5);
    for (int i = 0; i < 5; i++) check("t1_val", got_q[base+i], 2);

    // 2: rounding half-up on both signs
    base = got_q.size();
    v.delete(); repeat (5) v.push_back(0);
    for (int i = 0; i < 4; i++) v.push_back(t2[i]);
    send_run(v, -1, 0);
    idle(6);
    check("t2_count", got_q.size() - base, 4);
    for (int i = 0; i < 4; i++) check("t2_val", got_q[base+i], exp2[i]);
    check("t2_hold", $signed(m_data), 0);

    // 3: saturation both ways, then clear
    v.delete(); repeat (5) v.push_back(0); v.push_back(40000 * 1024);
    send_run(v, -1, 0);
    idle(4);
    check("t3_pos", got_q[got_q.size()-1], 32767);
    check("t3_flag1", sat_flag, 1);
    check("t3_cnt1", sat_count, 1);
    v.delete(); repeat (5) v.push_back(0); v.push_back(-40000 * 1024);
    send_run(v, -1, 0);
    idle(4);
    check("t3_neg", got_q[got_q.size()-1], -32768);
    check("t3_cnt2", sat_count, 2);
    pulse_clr();
    check("t3_flag_clr", sat_flag, 0);
    check("t3_cnt_clr", sat_count, 0);

    // 4: stalled consumer, 12 kept samples -> 8 retained, overflow
    @(posedge clk); #1; m_ready = 1'b0;
    v.delete(); repeat (5) v.push_back(0);
    for (int i = 0; i < 12; i++) v.push_back(longint'(100 + i) * 1024);
    send_run(v, -1, 0);
    idle(4);
    check("t4_fill", fill, 8);
    check("t4_ovf", ovf_flag, 1);
    check("t4_head", $signed(m_data), 100);
    base = got_q.size();
    @(posedge clk); #1; m_ready = 1'b1;
    idle(12);
    check("t4_count", got_q.size() - base, 8);
    for (int i = 0; i < 8; i++) check("t4_val", got_q[base+i], 100 + i);
    check("t4_fill_end", fill, 0);
    pulse_clr();
    check("t4_ovf_clr", ovf_flag, 0);

    // 5: full FIFO, pop and write in the same cycle
    @(posedge clk); #1; m_ready = 1'b0;
    base = got_q.size();
    v.delete(); repeat (5) v.push_back(0);
    for (int i = 0; i < 8; i++) v.push_back(longint'(200 + i) * 1024);
    send_run(v, -1, 0);
    idle(4);
    check("t5_fill_full", fill, 8);
    v.delete(); repeat (5) v.push_back(0); v.push_back(300 * 1024);
    send_run(v, 8, 2);
    check("t5_fill_stays", fill, 8);
    check("t5_no_ovf", ovf_flag, 0);
    @(posedge clk); #1; m_ready = 1'b1;
    idle(12);
    check("t5_count", got_q.size() - base, 9);
    for (int i = 0; i < 8; i++) check("t5_val", got_q[base+i], 200 + i);
    check("t5_new", got_q[base+8], 300);

    // 6: gap restarts warm-up; then async reset with a partly filled FIFO
    base = got_q.size();
    v.delete(); repeat (3) v.push_back(5 * 1024);
    send_run(v, -1, 0);
    v.delete(); repeat (7) v.push_back(7 * 1024);
    send_run(v, -1, 0);
    idle(6);
    check("t6_count", got_q.size() - base, 2);
    check("t6_val", got_q[got_q.size()-1], 7);
    @(posedge clk); #1; m_ready = 1'b0;
    v.delete(); repeat (5) v.push_back(0);
    for (int i = 0; i < 4; i++) v.push_back(longint'(400 + i) * 1024);
    send_run(v, -1, 0);
    idle(4);
    check("t6_fill4", fill, 4);
    check("t6_valid4", m_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_valid", m_valid, 0);
    check("t6_async_fill", fill, 0);
    @(posedge clk); #1; reset = 1'b1;
    idle(3);
    check("t6_post_valid", m_valid, 0);
    check("t6_post_data", m_data, 0);
    check("t6_post_fill", fill, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
